// File: rtl/aes_pkg.sv
// AES-128 shared widths, sequencer states and the byte-level round primitives.
// Byte 0 sits in bits [127:120]; bytes are column-major (index = row + 4*col).
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = gf_mul(x, x);
        r = t;
        for (int k = 0; k < 6; k++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            o[103-32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Plaintext, ciphertext and round-key handshakes of the AES encrypt sequencer.
// master is the sequencer side, slave the surrounding system.
interface aes_enc_ctrl_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_block;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_block;
    logic                 rk_req;
    logic [3:0]           rk_idx;
    logic                 rk_valid;
    logic [AES_BLK_W-1:0] rk_data;
    logic                 busy;

    modport master (
        input  in_valid, in_block, out_ready, rk_valid, rk_data,
        output in_ready, out_valid, out_block, rk_req, rk_idx, busy
    );

    modport slave (
        output in_valid, in_block, out_ready, rk_valid, rk_data,
        input  in_ready, out_valid, out_block, rk_req, rk_idx, busy
    );

endinterface

// File: rtl/aes_round_comb.sv
// One AES round, shared by every round: key-only, full, or final (no MixColumns).
// Combinational; the caller registers state_out.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 is_first,
    input  logic                 is_final,
    output logic [AES_BLK_W-1:0] state_out
);

    logic [AES_BLK_W-1:0] sb;
    logic [AES_BLK_W-1:0] sr;
    logic [AES_BLK_W-1:0] mc;

    assign sb = sub_bytes(state_in);
    assign sr = shift_rows(sb);
    assign mc = mix_columns(sr);

    always_comb begin
        unique case (1'b1)
            is_first: state_out = state_in ^ round_key;
            is_final: state_out = sr ^ round_key;
            default:  state_out = mc ^ round_key;
        endcase
    end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encrypt sequencer: one round per fetched key, 0..NR.
// Owns the state register, round counter and both block handshakes.
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
)(
    input  logic           clk,
    input  logic           rst_n,
    aes_enc_ctrl_if.master bus
);

    aes_state_e           state;
    logic [3:0]           round;
    logic [AES_BLK_W-1:0] state_reg;
    logic [AES_BLK_W-1:0] next_blk;
    logic                 is_last;

    assign is_last = (round == 4'(NR));

    aes_round_comb u_round (
        .state_in  (state_reg),
        .round_key (bus.rk_data),
        .is_first  (round == 4'd0),
        .is_final  (is_last),
        .state_out (next_blk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round     <= '0;
            state_reg <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    state_reg <= bus.in_block;
                    round     <= '0;
                    state     <= RUN;
                end
                // The last round leaves round at NR so it never wraps.
                RUN: if (bus.rk_valid) begin
                    state_reg <= next_blk;
                    if (is_last) state <= DONE;
                    else         round <= round + 4'd1;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_block = bus.out_valid ? state_reg : '0;
    assign bus.rk_req    = (state == RUN);
    assign bus.rk_idx    = bus.rk_req ? round : 4'd0;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl: block-level AES model, key-expansion
// responder with random stalls, per-cycle output comparison.
module tb_aes_enc_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_enc_ctrl_if bus();

    aes_enc_ctrl #(.NR(AES_NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    logic [127:0] cur_key = '0;
    bit           gap_mode = 1'b0;

    int           m_mode = 0;
    int           m_k = 0;
    int           m_stall = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] exp_q [$];
    logic [127:0] last_ob = '0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           acc_cnt = 0;
    int           out_cnt = 0;
    int           acc_log [$];
    logic [127:0] ct_log [$];
    int           idx_log [$];
    int           lat_last = -1;
    bit           prev_ov = 1'b0;
    int           stall_left = 0;
    bit           prev_take = 1'b1;
    int           resp_stalls = 0;

    int           n0, a0;
    logic [127:0] p3, p4, rkey, rpt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] x;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            x = w[i-1];
            if (i % 4 == 0) begin
                x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
                rc = bmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ x;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0b, a1b, a2b, a3b;
        logic [127:0] k, res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
                for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0b = s[4*c]; a1b = s[4*c+1]; a2b = s[4*c+2]; a3b = s[4*c+3];
                        s[4*c]   = bmul(a0b, 8'h02) ^ bmul(a1b, 8'h03) ^ a2b ^ a3b;
                        s[4*c+1] = a0b ^ bmul(a1b, 8'h02) ^ bmul(a2b, 8'h03) ^ a3b;
                        s[4*c+2] = a0b ^ a1b ^ bmul(a2b, 8'h02) ^ bmul(a3b, 8'h03);
                        s[4*c+3] = bmul(a0b, 8'h03) ^ a1b ^ a2b ^ bmul(a3b, 8'h02);
                    end
                end
            end
            k = round_key(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic set_key(input logic [127:0] key);
        cur_key = key;
        for (int r = 0; r <= AES_NR; r++) rk[r] = round_key(key, r);
    endtask

    // Reference model: advances on each clock edge from the inputs only.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0;
            m_k = 0;
            m_stall = 0;
            exp_q.delete();
        end else begin
            cyc++;
            case (m_mode)
                0: if (bus.in_valid) begin
                    m_ct = aes_ref(cur_key, bus.in_block);
                    exp_q.push_back(m_ct);
                    m_mode = 1;
                    m_k = 0;
                    m_stall = 0;
                    acc_cyc = cyc - 1;
                    acc_cnt++;
                    acc_log.push_back(acc_cyc);
                end
                1: if (!bus.rk_valid) m_stall++;
                   else if (m_k == AES_NR) m_mode = 2;
                   else m_k++;
                2: if (bus.out_ready) begin
                    if (exp_q.size() > 0) chk("order", last_ob, exp_q.pop_front());
                    ct_log.push_back(last_ob);
                    out_cnt++;
                    m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Compare process: outputs sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("in_ready", bus.in_ready, m_mode == 0);
        chk("out_valid", bus.out_valid, m_mode == 2);
        chk("busy", bus.busy, m_mode != 0);
        chk("rk_req", bus.rk_req, m_mode == 1);
        if (m_mode == 1 || !rst_n) chk("rk_idx", bus.rk_idx, (m_mode == 1) ? 4'(m_k) : 4'd0);
        if (!rst_n) chk("rst_out_block", bus.out_block, '0);
        if (m_mode == 2) begin
            chk("out_block", bus.out_block, m_ct);
            last_ob = bus.out_block;
        end
        if (bus.rk_req) idx_log.push_back(int'(bus.rk_idx));
        if (bus.out_valid && !prev_ov) begin
            lat_last = cyc - acc_cyc;
            chk("latency", 128'(lat_last), 128'(12 + m_stall));
        end
        prev_ov = bus.out_valid;
    end

    // Key-expansion responder; random noise on rk_valid while not requested.
    initial forever begin
        @(negedge clk);
        if (bus.rk_req) begin
            if (prev_take) stall_left = gap_mode ? int'($urandom_range(0, 3)) : 0;
            if (stall_left > 0) begin
                stall_left--;
                resp_stalls++;
                bus.rk_valid = 1'b0;
                bus.rk_data = {$urandom, $urandom, $urandom, $urandom};
                prev_take = 1'b0;
            end else begin
                bus.rk_valid = 1'b1;
                bus.rk_data = rk[bus.rk_idx];
                prev_take = 1'b1;
            end
        end else begin
            bus.rk_valid = 1'($urandom_range(0, 1));
            bus.rk_data = {$urandom, $urandom, $urandom, $urandom};
            prev_take = 1'b1;
        end
    end

    task automatic send(input logic [127:0] pt);
        int n;
        n = acc_cnt;
        bus.in_block = pt;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && acc_cnt == n; i++) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("accept_timeout", 128'(acc_cnt != n), 128'(1));
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 400 && out_cnt < n; i++) @(negedge clk);
        chk("out_timeout", 128'(out_cnt >= n), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.out_ready = 1'b1;
        bus.rk_valid = 1'b0;
        bus.rk_data = '0;
        build_sbox();
        chk("model_c1", aes_ref(K1, P1), C1);
        chk("model_b", aes_ref(K2, P2), C2);
        chk("model_rk10", round_key(K2, 10), RK10);
        set_key(K1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        idx_log.delete();
        send(P1);
        wait_out(1);
        chk("c1_ct", ct_log[0], C1);
        chk("c1_lat", 128'(lat_last), 128'(12));
        chk("c1_idx_n", 128'(idx_log.size()), 128'(11));
        for (int i = 0; i < 11; i++) chk("c1_idx", 128'(idx_log[i]), 128'(i));

        set_key(K2);
        gap_mode = 1'b1;
        resp_stalls = 0;
        send(P2);
        wait_out(2);
        gap_mode = 1'b0;
        chk("b_ct", ct_log[1], C2);
        chk("b_lat", 128'(lat_last), 128'(12 + resp_stalls));

        set_key(K1);
        bus.out_ready = 1'b0;
        send(P1);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        chk("hold_reach", bus.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_ob", bus.out_block, C1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_in_ready", bus.in_ready, 1'b1);
        wait_out(3);

        set_key(K2);
        n0 = out_cnt;
        a0 = acc_cnt;
        p3 = {$urandom, $urandom, $urandom, $urandom};
        p4 = {$urandom, $urandom, $urandom, $urandom};
        bus.in_block = p3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == a0; i++) @(negedge clk);
        bus.in_block = p4;
        for (int i = 0; i < 100 && acc_cnt == a0 + 1; i++) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("second_accept", 128'(acc_cnt), 128'(a0 + 2));
        chk("issue_gap", 128'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 128'(13));
        wait_out(n0 + 2);
        chk("ord_first", ct_log[n0], aes_ref(K2, p3));
        chk("ord_second", ct_log[n0+1], aes_ref(K2, p4));

        for (int j = 0; j < 4; j++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt = {$urandom, $urandom, $urandom, $urandom};
            set_key(rkey);
            gap_mode = (j % 2) == 1;
            n0 = out_cnt;
            send(rpt);
            wait_out(n0 + 1);
            chk("rand_ct", ct_log[n0], aes_ref(rkey, rpt));
        end
        gap_mode = 1'b0;

        set_key(K1);
        send(P1);
        for (int i = 0; i < 50 && !(bus.rk_req && bus.rk_idx == 4'd5); i++) @(negedge clk);
        chk("rst_reach_idx5", bus.rk_idx, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1'b1);
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_block", bus.out_block, '0);
        chk("arst_rk_req", bus.rk_req, 1'b0);
        chk("arst_rk_idx", bus.rk_idx, 4'd0);
        chk("arst_busy", bus.busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n0 = out_cnt;
        send(P1);
        wait_out(n0 + 1);
        chk("post_rst_ct", ct_log[n0], C1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
